// File: rtl/cfg_sr_pkg.sv
// Shared types and sizing for the dynamic configuration shift-register chain.
// Holds the FSM encoding, the default frame length and the bit counter width.
package cfg_sr_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_t;

  localparam int SIZESRDYN_DEF = 16;

  // Counter must hold SIZESRDYN+1 so an over-long frame stays distinguishable.
  function automatic int bit_cnt_w(input int size);
    return $clog2(size + 2);
  endfunction

  localparam int BIT_CNT_W = bit_cnt_w(SIZESRDYN_DEF);

endpackage

// File: rtl/cfg_shift_core.sv
// Dynamic shift register with saturating bit counter and registered daisy-chain tap.
// One bit per shift cycle; sdata_out lags the shifted-in bit by SIZESRDYN cycles.
module cfg_shift_core #(
  parameter int SIZESRDYN = 16,
  parameter int BCW       = 5
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 shift,
  input  logic                 restart,
  input  logic                 clr,
  input  logic                 sdata_in,
  output logic [SIZESRDYN-1:0] dyn_sr,
  output logic [BCW-1:0]       bit_cnt,
  output logic                 sdata_out
);

  localparam logic [BCW-1:0] CNT_MAX = BCW'(SIZESRDYN + 1);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      dyn_sr    <= '0;
      bit_cnt   <= '0;
      sdata_out <= 1'b0;
    end else begin
      sdata_out <= dyn_sr[SIZESRDYN-1];
      if (shift) begin
        dyn_sr <= {dyn_sr[SIZESRDYN-2:0], sdata_in};
      end
      // restart makes the first bit of a new frame count as 1 regardless of stale counts
      if (clr) begin
        bit_cnt <= '0;
      end else if (shift) begin
        if (restart) begin
          bit_cnt <= BCW'(1);
        end else if (bit_cnt != CNT_MAX) begin
          bit_cnt <= bit_cnt + BCW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/dyn_cfg_capture.sv
// Captures a serial dynamic-config frame, length-checks it and latches it one cycle after sel_stat.
// Optional macro CFG_CHANGED_EN adds a cfg_changed pulse when a good latch changes dyn_cfg.
module dyn_cfg_capture
  import cfg_sr_pkg::*;
#(
  parameter int SIZESRDYN = SIZESRDYN_DEF,
  parameter int CNTW      = 8
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 sel_dyn,
  input  logic                 sel_stat,
  input  logic                 en_fin,
  input  logic                 sdata_in,
  output logic [SIZESRDYN-1:0] dyn_cfg,
  output logic                 cfg_valid,
  output logic                 len_err,
  output logic [CNTW-1:0]      frame_cnt,
`ifdef CFG_CHANGED_EN
  output logic                 cfg_changed,
`endif
  output logic                 sdata_out
);

  localparam int BCW = bit_cnt_w(SIZESRDYN);
  localparam logic [BCW-1:0] FULL = BCW'(SIZESRDYN);

  state_t               state, state_nxt;
  logic                 shift_cond;
  logic                 en_fin_q;
  logic                 core_restart, core_clr;
  logic                 latch_good, err_set, err_clr;
  logic [SIZESRDYN-1:0] dyn_sr;
  logic [BCW-1:0]       bit_cnt;

  assign shift_cond = sel_dyn & ~sel_stat & ~en_fin;

  cfg_shift_core #(
    .SIZESRDYN (SIZESRDYN),
    .BCW       (BCW)
  ) u_core (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .shift     (shift_cond),
    .restart   (core_restart),
    .clr       (core_clr),
    .sdata_in  (sdata_in),
    .dyn_sr    (dyn_sr),
    .bit_cnt   (bit_cnt),
    .sdata_out (sdata_out)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= S_IDLE;
      en_fin_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      en_fin_q <= en_fin;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (shift_cond) state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        if (shift_cond)                state_nxt = S_SHIFT;
        else if (sel_stat && !sel_dyn) state_nxt = S_DONE;
        else                           state_nxt = S_IDLE;
      end
      S_DONE: begin
        // en_fin high holds us here; its falling edge releases to idle
        if (shift_cond)              state_nxt = S_SHIFT;
        else if (en_fin_q && !en_fin) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    core_restart = (state != S_SHIFT);
    core_clr     = 1'b0;
    latch_good   = 1'b0;
    err_set      = 1'b0;
    err_clr      = 1'b0;
    case (state)
      S_IDLE: begin
        if (shift_cond)    err_clr = 1'b1;
        else if (sel_stat) err_set = 1'b1;
      end
      S_SHIFT: begin
        if (shift_cond) begin
          err_clr = 1'b0;
        end else if (sel_stat && !sel_dyn) begin
          if (bit_cnt == FULL) latch_good = 1'b1;
          else                 err_set    = 1'b1;
        end else if (sel_stat) begin
          err_set = 1'b1;
        end else begin
          // gap or en_fin mid-frame: discard the partial count
          err_set  = 1'b1;
          core_clr = 1'b1;
        end
      end
      S_DONE: begin
        if (shift_cond) err_clr  = 1'b1;
        else            core_clr = 1'b1;
      end
      default: core_clr = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      dyn_cfg   <= '0;
      cfg_valid <= 1'b0;
      len_err   <= 1'b0;
      frame_cnt <= '0;
    end else begin
      if (err_set)      len_err <= 1'b1;
      else if (err_clr) len_err <= 1'b0;
      if (latch_good) begin
        dyn_cfg   <= dyn_sr;
        cfg_valid <= 1'b1;
        frame_cnt <= frame_cnt + CNTW'(1);
      end
    end
  end

`ifdef CFG_CHANGED_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cfg_changed <= 1'b0;
    end else begin
      cfg_changed <= latch_good & (~cfg_valid | (dyn_sr != dyn_cfg));
    end
  end
`endif

endmodule

// File: tb/tb_dyn_cfg_capture.sv
// Directed bench for dyn_cfg_capture with an expected-result queue per latch strobe.
// Covers good/short/long frames, post-load wait, gap, protocol error, reset and counter wrap.
module tb_dyn_cfg_capture;
  import cfg_sr_pkg::*;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        sel_dyn, sel_stat, en_fin, sdata_in;
  logic [15:0] dyn_cfg;
  logic        cfg_valid, len_err, sdata_out;
  logic [7:0]  frame_cnt;
`ifdef CFG_CHANGED_EN
  logic        cfg_changed;
`endif

  dyn_cfg_capture #(.SIZESRDYN(16), .CNTW(8)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .sel_dyn   (sel_dyn),
    .sel_stat  (sel_stat),
    .en_fin    (en_fin),
    .sdata_in  (sdata_in),
    .dyn_cfg   (dyn_cfg),
    .cfg_valid (cfg_valid),
    .len_err   (len_err),
    .frame_cnt (frame_cnt),
`ifdef CFG_CHANGED_EN
    .cfg_changed (cfg_changed),
`endif
    .sdata_out (sdata_out)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] cfg;
    logic        valid;
    logic        err;
    logic [7:0]  cnt;
    logic        chg;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] m_cfg;
  logic        m_valid, m_err;
  logic [7:0]  m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic model_reset();
    m_cfg = '0; m_valid = 1'b0; m_err = 1'b0; m_cnt = '0;
    sb.delete();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_dyn_cfg"},   32'(dyn_cfg),   32'h0);
    chk({tag, "_cfg_valid"}, 32'(cfg_valid), 32'h0);
    chk({tag, "_len_err"},   32'(len_err),   32'h0);
    chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'h0);
    chk({tag, "_sdata_out"}, 32'(sdata_out), 32'h0);
  endtask

  task automatic do_reset();
    sel_dyn = 0; sel_stat = 0; en_fin = 0; sdata_in = 0;
    RST_N = 1'b0;
    #1;
    model_reset();
    chk_reset_outputs("rst");
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  // Shift nbits of data MSB first, checking first-shift error clear and the daisy-chain lag.
  task automatic shift_bits(input logic [31:0] data, input int nbits, input bit chk_first);
    for (int j = 0; j < nbits; j++) begin
      sel_dyn  = 1'b1;
      sdata_in = data[nbits-1-j];
      step();
      if (j == 0) begin
        m_err = 1'b0;
        if (chk_first) chk("first_shift_err_clr", 32'(len_err), 32'h0);
      end
      if (j >= 16) chk("sdata_lag", 32'(sdata_out), 32'(data[nbits-1-(j-16)]));
    end
    sel_dyn  = 1'b0;
    sdata_in = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] data, input int nbits, input bit chk_first);
    exp_t e;
    exp_t got;
    shift_bits(data, nbits, chk_first);
    if (nbits == 16) begin
      e.chg   = !m_valid || (m_cfg != data[15:0]);
      m_cfg   = data[15:0];
      m_valid = 1'b1;
      m_cnt   = m_cnt + 8'd1;
    end else begin
      e.chg = 1'b0;
      m_err = 1'b1;
    end
    e.cfg = m_cfg; e.valid = m_valid; e.err = m_err; e.cnt = m_cnt;
    sb.push_back(e);
    sel_stat = 1'b1;
    step();
    sel_stat = 1'b0;
    got = sb.pop_front();
    chk("latch_dyn_cfg",   32'(dyn_cfg),   32'(got.cfg));
    chk("latch_cfg_valid", 32'(cfg_valid), 32'(got.valid));
    chk("latch_len_err",   32'(len_err),   32'(got.err));
    chk("latch_frame_cnt", 32'(frame_cnt), 32'(got.cnt));
`ifdef CFG_CHANGED_EN
    chk("latch_cfg_changed", 32'(cfg_changed), 32'(got.chg));
    step();
    chk("cfg_changed_pulse_end", 32'(cfg_changed), 32'h0);
`endif
  endtask

  initial begin
    logic [31:0] d;
    do_reset();
    chk("rst_state", 32'(dut.state), 32'(S_IDLE));

    // short frame: 15 bits
    send_frame(32'h0000_1234, 15, 1'b0);
    // good frame
    send_frame(32'h0000_1234, 16, 1'b1);
    // long frame: FFFF plus a trailing 0, then good A5A5
    send_frame(32'h0001_FFFE, 17, 1'b1);
    send_frame(32'h0000_A5A5, 16, 1'b1);

    // post-load wait: sel_dyn with en_fin high is ignored
    sel_dyn = 1'b1; en_fin = 1'b1; sdata_in = 1'b1;
    repeat (20) step();
    chk("wait_dyn_sr",  32'(dut.u_core.dyn_sr),  32'h0000_A5A5);
    chk("wait_bit_cnt", 32'(dut.u_core.bit_cnt), 32'h0);
    chk("wait_dyn_cfg", 32'(dyn_cfg),            32'h0000_A5A5);
    chk("wait_state",   32'(dut.state),          32'(S_DONE));
    sel_dyn = 1'b0; en_fin = 1'b0; sdata_in = 1'b0;
    step();
    chk("en_fin_fall_state", 32'(dut.state), 32'(S_IDLE));

    // 20-bit run then a gap: abort with error, count cleared
    shift_bits(32'h000B_5A3C, 20, 1'b1);
    step();
    chk("gap_len_err", 32'(len_err),             32'h1);
    chk("gap_bit_cnt", 32'(dut.u_core.bit_cnt),  32'h0);
    chk("gap_state",   32'(dut.state),           32'(S_IDLE));
    chk("gap_dyn_cfg", 32'(dyn_cfg),             32'h0000_A5A5);

    // sel_stat together with sel_dyn: protocol error, no latch
    shift_bits(32'h0000_BEEF, 16, 1'b1);
    sel_dyn = 1'b1; sel_stat = 1'b1;
    step();
    sel_dyn = 1'b0; sel_stat = 1'b0;
    m_err = 1'b1;
    chk("proto_len_err",   32'(len_err),   32'h1);
    chk("proto_dyn_cfg",   32'(dyn_cfg),   32'h0000_A5A5);
    chk("proto_frame_cnt", 32'(frame_cnt), 32'(m_cnt));
    chk("proto_state",     32'(dut.state), 32'(S_IDLE));
    send_frame(32'h0000_0F0F, 16, 1'b1);

    // reset after 8 bits of a frame
    shift_bits(32'h0000_00FF, 8, 1'b0);
    RST_N = 1'b0;
    #1;
    model_reset();
    chk_reset_outputs("midrst");
    @(negedge CLK);
    RST_N = 1'b1;
    send_frame(32'h0000_1234, 16, 1'b0);

    // change detection sequence from a clean reset
    do_reset();
    send_frame(32'h0000_1234, 16, 1'b0);
    send_frame(32'h0000_1234, 16, 1'b0);
    send_frame(32'h0000_4321, 16, 1'b0);

    // frame counter wraps to zero
    while (m_cnt != 8'hFF) begin
      d = {16'h0, 16'($urandom)};
      send_frame(d, 16, 1'b0);
    end
    send_frame(32'h0000_C3C3, 16, 1'b0);
    chk("cnt_wrap", 32'(frame_cnt), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
